seg_counter_mux: RTL
====================

# seg_counter_mux

Parametrised multi-digit counter with a time-multiplexed 7-segment driver for the IO shield. It replaces the fixed 4-digit hex counter and its derived clocks with single-clock tick enables. It adds count enable, up/down counting, synchronous load, a hex/BCD mode and a wrap pulse. It sits between the top level's button/DIP inputs and the `io_seg`/`io_sel` pins.

## Interface
- `DIGITS`, 4: number of digits, 1–8; the counter is 4*DIGITS bits wide.
- `SCAN_DIV`, 16: scan prescaler width; the scan tick fires every 2^SCAN_DIV clocks.
- `COUNT_DIV`, 24: count prescaler width; the count tick fires every 2^COUNT_DIV clocks.

Ports:
- `clk`  in  1  system clock (100 MHz); the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable, sampled on the count tick.
- `up`  in  1  direction: 1 = increment, 0 = decrement.
- `bcd`  in  1  mode: 1 = each digit counts 0–9; 0 = each digit counts 0–F.
- `load`  in  1  synchronous load strobe.
- `load_value`  in  4*DIGITS  value written on `load`.
- `count`  out  4*DIGITS  current counter value, registered.
- `wrap`  out  1  one-clock pulse on wrap-around.
- `seg`  out  8  segments, active-low; bit0–6 = a–g, bit7 = dp; dp is always off.
- `sel`  out  DIGITS  digit select, one-hot, active-low; bit0 is the least-significant digit.

## Operation
- Two free-running prescalers, each reset to 0. A tick is asserted for one clock when the prescaler is all-ones. No derived clocks are generated.
- Scan tick: the digit index advances 0, 1, …, DIGITS-1, then back to 0.
- Count tick with `en`=1: `count` steps by ±1 in the selected radix. Carries and borrows ripple across digits.
  - Hex mode: all-F + 1 gives 0; 0 − 1 gives all-F.
  - BCD mode: all-9 + 1 gives 0; 0 − 1 gives all-9.
- `wrap` is asserted in the clock where `count` is updated by a wrapping step.
- BCD mode with a digit > 9 present (after a mode switch or a hex load): that digit is treated as 9 before the step is applied. Changing `bcd` alone never alters `count`.
- `load`:
  - `count` takes `load_value` on the next edge. In BCD mode each loaded digit > 9 is clamped to 9.
  - `load` has priority over a simultaneous count tick. That tick is discarded and `wrap` stays 0.
- Display: the registered `sel`/`seg` pair is driven from the current digit index and the nibble of `count` at that index.
  - Font: 0 = C0, 1 = F9, 2 = A4, 3 = B0, 4 = 99, 5 = 92, 6 = 82, 7 = F8, 8 = 80, 9 = 90, A = 88, b = 83, C = C6, d = A1, E = 86, F = 8E (hex).
- Reset values: `count` = 0, `wrap` = 0, `sel` = all ones (all digits off), `seg` = FF, digit index = 0, both prescalers = 0.

## Timing
- Count tick at edge N: the new `count` and the `wrap` pulse are visible after edge N+1.
- `seg`/`sel` are re-registered every clock. They reflect a digit-index or `count` change one clock later, and both update on the same edge (no skew between them).
- `load` sampled at edge N: `count` = `load_value` after edge N.
- After reset release, the first scan tick occurs at clock 2^SCAN_DIV. `sel` first leaves all-ones on the edge after reset release (digit 0).
- Asserting `rst_n` mid-operation clears all state immediately, independent of `clk`.

## Configuration
- `SEG_COUNTER_LZB_EN` defined: leading-zero blanking. Every digit above the most-significant non-zero digit drives `seg` = FF while its `sel` bit is still active. Digit 0 is never blanked, so a count of 0 shows "0".
- `SEG_COUNTER_LZB_EN` undefined: all DIGITS digits are always displayed, including leading zeros.

## Test plan
Use `SCAN_DIV`=2, `COUNT_DIV`=3, `DIGITS`=4 unless stated otherwise.
- Reset: hold `rst_n`=0 mid-count → `count`=0000, `wrap`=0, `sel`=1111, `seg`=FF, asynchronously.
- Scan order: run 16 clocks with `count`=0x1F90 → `sel` cycles 1110, 1101, 1011, 0111, with `seg` = C0, 90, 8E, F9 respectively, each `sel`/`seg` pair changing on the same edge.
- Hex wrap: load FFFE, `up`=1, `en`=1 → FFFF, then 0000 with a single-clock `wrap`; `en`=0 → `count` holds across ticks.
- BCD: load 0999, `bcd`=1 → the next tick gives 1000. Load 9999 → the next tick gives 0000 with `wrap`. `up`=0 from 0000 → 9999 with `wrap`. Load 0x00A5 in BCD mode → `count`=0095.
- Load/tick collision: `load`=1 with `load_value`=1234 in a count-tick clock → `count`=1234, `wrap`=0, and no step that tick.
- LZB (macro defined): `count`=0x0042 → digits 3 and 2 show FF, digits 1 and 0 show 99 and A4; `count`=0 → only digit 0 shows C0. With the macro undefined, digits 3 and 2 show C0.

Source files
------------

// File: rtl/seg_counter_mux.sv
// seg_counter_mux
//   Multi-digit hex/BCD up/down counter with a time-multiplexed, active-low
//   7-segment driver. Runs entirely on clk. The scan and count rates come from
//   free-running prescalers that issue one-clock tick enables.
//
// Parameters
//   DIGITS    : number of digits (1..8); the counter is 4*DIGITS bits wide
//   SCAN_DIV  : scan prescaler width; a scan tick occurs every 2^SCAN_DIV clocks
//   COUNT_DIV : count prescaler width; a count tick occurs every 2^COUNT_DIV clocks
//
// Ports
//   clk        : system clock, the only clock
//   rst_n      : asynchronous active-low reset
//   en         : count enable, applied when the registered count tick fires
//   up         : 1 = increment, 0 = decrement
//   bcd        : 1 = digits count 0-9, 0 = digits count 0-F
//   load       : synchronous load strobe; it has priority over a count step
//   load_value : value loaded on load (digits above 9 are clamped in BCD mode)
//   count      : registered counter value
//   wrap       : one-clock pulse when a step wraps the counter
//   seg        : segments a-g on bits 0-6 and dp on bit 7, all active-low
//   sel        : one-hot active-low digit select; bit 0 is the LS digit
//
// Build option
//   SEG_COUNTER_LZB_EN : when defined, leading zeros are blanked. Digit 0 is
//                        never blanked.

module seg_counter_mux #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 16,
  parameter int COUNT_DIV = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  bcd,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     sel
);

  localparam int CW    = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [SCAN_DIV-1:0]  scan_pre_r;
  logic [COUNT_DIV-1:0] count_pre_r;
  logic                 scan_tick_s;
  logic                 count_tick_s;
  logic                 count_tick_r;
  logic [IDX_W-1:0]     digit_idx_r;
  logic [CW-1:0]        count_r;
  logic                 wrap_r;
  logic [7:0]           seg_r;
  logic [DIGITS-1:0]    sel_r;

  logic [CW-1:0]        base_s;
  logic [CW-1:0]        step_s;
  logic                 step_wrap_s;
  logic                 carry_s;
  logic [3:0]           dig_s;
  logic [3:0]           max_s;
  logic [CW-1:0]        load_s;
  logic [3:0]           nib_s;
  logic                 cur_blank_s;
  logic [DIGITS-1:0]    blank_s;

  // Replace every nibble above 9 with 9
  function automatic logic [CW-1:0] clamp_bcd(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Active-low 7-segment font, dp (bit 7) kept off
  function automatic logic [7:0] seg_font(input logic [3:0] n);
    logic [7:0] f;
    case (n)
      4'h0:    f = 8'hC0;
      4'h1:    f = 8'hF9;
      4'h2:    f = 8'hA4;
      4'h3:    f = 8'hB0;
      4'h4:    f = 8'h99;
      4'h5:    f = 8'h92;
      4'h6:    f = 8'h82;
      4'h7:    f = 8'hF8;
      4'h8:    f = 8'h80;
      4'h9:    f = 8'h90;
      4'hA:    f = 8'h88;
      4'hB:    f = 8'h83;
      4'hC:    f = 8'hC6;
      4'hD:    f = 8'hA1;
      4'hE:    f = 8'h86;
      4'hF:    f = 8'h8E;
      default: f = 8'hFF;
    endcase
    return f;
  endfunction

  assign scan_tick_s  = &scan_pre_r;
  assign count_tick_s = &count_pre_r;

  // Free-running prescalers; the count tick is registered so a step lands one clock after its tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_pre_r   <= {SCAN_DIV{1'b0}};
      count_pre_r  <= {COUNT_DIV{1'b0}};
      count_tick_r <= 1'b0;
    end else begin
      scan_pre_r   <= scan_pre_r + SCAN_DIV'(1);
      count_pre_r  <= count_pre_r + COUNT_DIV'(1);
      count_tick_r <= count_tick_s;
    end
  end

  // Digit index advances on every scan tick and wraps after the last digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_idx_r <= IDX_W'(0);
    end else if (scan_tick_s) begin
      if (digit_idx_r == IDX_W'(DIGITS - 1)) begin
        digit_idx_r <= IDX_W'(0);
      end else begin
        digit_idx_r <= digit_idx_r + IDX_W'(1);
      end
    end else begin
      digit_idx_r <= digit_idx_r;
    end
  end

  // Ripple a +1/-1 through the digits in the selected radix; the carry out is the wrap
  always_comb begin
    max_s   = bcd ? 4'd9 : 4'hF;
    // BCD digits above 9 count as 9 before the step
    base_s  = bcd ? clamp_bcd(count_r) : count_r;
    step_s  = base_s;
    carry_s = 1'b1;
    dig_s   = 4'h0;
    for (int i = 0; i < DIGITS; i++) begin
      dig_s = base_s[4*i +: 4];
      if (carry_s) begin
        if (up) begin
          if (dig_s == max_s) begin
            dig_s   = 4'h0;
            carry_s = 1'b1;
          end else begin
            dig_s   = dig_s + 4'd1;
            carry_s = 1'b0;
          end
        end else begin
          if (dig_s == 4'h0) begin
            dig_s   = max_s;
            carry_s = 1'b1;
          end else begin
            dig_s   = dig_s - 4'd1;
            carry_s = 1'b0;
          end
        end
      end else begin
        dig_s = base_s[4*i +: 4];
      end
      step_s[4*i +: 4] = dig_s;
    end
    step_wrap_s = carry_s;
  end

  // Load value, clamped to 9 per digit in BCD mode
  always_comb begin
    if (bcd) begin
      load_s = clamp_bcd(load_value);
    end else begin
      load_s = load_value;
    end
  end

  // Counter and wrap pulse; load wins over a coincident count tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
      wrap_r  <= 1'b0;
    end else if (load) begin
      count_r <= load_s;
      wrap_r  <= 1'b0;
    end else if (count_tick_r && en) begin
      count_r <= step_s;
      wrap_r  <= step_wrap_s;
    end else begin
      count_r <= count_r;
      wrap_r  <= 1'b0;
    end
  end

`ifdef SEG_COUNTER_LZB_EN
  logic lead_zero_s;

  // Blank each digit above the most-significant non-zero digit; digit 0 always shows
  always_comb begin
    lead_zero_s = 1'b1;
    blank_s     = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i > 0; i--) begin
      lead_zero_s = lead_zero_s & (count_r[4*i +: 4] == 4'h0);
      blank_s[i]  = lead_zero_s;
    end
  end
`else
  assign blank_s = {DIGITS{1'b0}};
`endif

  // Pick the nibble and the blank flag of the digit currently being scanned
  always_comb begin
    nib_s       = 4'h0;
    cur_blank_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx_r == IDX_W'(i)) begin
        nib_s       = count_r[4*i +: 4];
        cur_blank_s = blank_s[i];
      end else begin
        nib_s       = nib_s;
        cur_blank_s = cur_blank_s;
      end
    end
  end

  // sel and seg are registered together every clock so they never skew
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r <= {DIGITS{1'b1}};
      seg_r <= 8'hFF;
    end else begin
      sel_r <= ~(DIGITS'(1) << digit_idx_r);
      seg_r <= cur_blank_s ? 8'hFF : seg_font(nib_s);
    end
  end

  assign count = count_r;
  assign wrap  = wrap_r;
  assign seg   = seg_r;
  assign sel   = sel_r;

endmodule
